// File: rtl/wb_slave_txfifo.sv
// wb_slave_txfifo: Wishbone classic slave feeding an egress byte FIFO.
// Define WB_SLAVE_TXFIFO_ERR_EN to terminate full DATA writes and LEVEL writes with wb_err_o.
module wb_slave_txfifo #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         ACK_WAIT   = 1,
  parameter logic [7:0] BASE_ADDR  = 8'h40
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       wb_cyc_i,
  input  logic       wb_stb_i,
  input  logic       wb_we_i,
  input  logic [7:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack_o,
  output logic       wb_err_o,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t        r_state;
  logic [2:0]    r_cnt;
  logic [1:0]    r_adr;
  logic [7:0]    r_dat, r_dat_o;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          r_we, r_ack, r_err, r_ovf, r_irq_en, r_irq;
  logic [3:0]    r_thr;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [LW-1:0] r_level;
  logic          w_req, w_commit, w_we, w_wr, w_full, w_empty, w_pop;
  logic          w_flush, w_dwr, w_push, w_drop, w_err;
  logic [1:0]    w_adr;
  logic [7:0]    w_dat, w_rdata, w_level;

  assign w_req    = wb_cyc_i && wb_stb_i && wb_adr_i[7:2] == BASE_ADDR[7:2];
  // The commit edge is the one that enters RESP; with no wait states it is the accepting edge itself.
  assign w_commit = (r_state == S_IDLE && ACK_WAIT == 0 && w_req) ||
                    (r_state == S_WAIT && wb_cyc_i && r_cnt == 3'd0);
  assign w_adr    = r_state == S_IDLE ? wb_adr_i[1:0] : r_adr;
  assign w_dat    = r_state == S_IDLE ? wb_dat_i : r_dat;
  assign w_we     = r_state == S_IDLE ? wb_we_i : r_we;
  assign w_level  = 8'(r_level);
  assign w_full   = r_level == LW'(FIFO_DEPTH);
  assign w_empty  = r_level == '0;
  assign tx_valid = !w_empty;
  assign tx_data  = mem[r_rptr];
  assign w_pop    = tx_valid && tx_ready;
  assign w_wr     = w_commit && w_we;
  assign w_dwr    = w_wr && w_adr == 2'd0;
  assign w_push   = w_dwr && (!w_full || w_pop);
  assign w_drop   = w_dwr && w_full && !w_pop;
  assign w_flush  = w_wr && w_adr == 2'd3 && w_dat[6];
`ifdef WB_SLAVE_TXFIFO_ERR_EN
  assign w_err    = w_drop || (w_wr && w_adr == 2'd2);
`else
  assign w_err    = 1'b0;
`endif
  assign w_rdata  = w_adr == 2'd0 ? (w_empty ? 8'h00 : tx_data) :
                    w_adr == 2'd1 ? {4'h0, r_irq, r_ovf, w_full, w_empty} :
                    w_adr == 2'd2 ? w_level : {r_irq_en, 3'b000, r_thr};
  assign wb_dat_o = r_dat_o;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign irq      = r_irq;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 3'd0;
      r_adr    <= 2'd0;
      r_dat    <= 8'h00;
      r_we     <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat_o  <= 8'h00;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_thr    <= 4'h0;
      r_irq    <= 1'b0;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat_o <= 8'h00;
      r_irq   <= r_irq_en && w_level <= {4'h0, r_thr};
      case (r_state)
        S_IDLE: if (w_req) begin
          r_adr   <= wb_adr_i[1:0];
          r_dat   <= wb_dat_i;
          r_we    <= wb_we_i;
          r_cnt   <= 3'(ACK_WAIT == 0 ? 0 : ACK_WAIT - 1);
          r_state <= S_WAIT;
        end
        S_WAIT: if (!wb_cyc_i) r_state <= S_IDLE;
          else if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        default: r_state <= S_IDLE;
      endcase
      if (w_commit) begin
        r_state <= S_RESP;
        r_ack   <= !w_err;
        r_err   <= w_err;
        r_dat_o <= w_we ? 8'h00 : w_rdata;
      end
      if (w_drop) r_ovf <= 1'b1;
      else if (w_wr && w_adr == 2'd1 && w_dat[2]) r_ovf <= 1'b0;
      if (w_wr && w_adr == 2'd3) begin
        r_irq_en <= w_dat[7];
        r_thr    <= w_dat[3:0];
      end
    end

  // Flush wins over any pop or push landing in the same cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_push);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end

  always_ff @(posedge wb_clk_i)
    if (w_push) mem[r_wptr] <= w_dat;
endmodule

// File: tb/tb_wb_slave_txfifo.sv
// tb_wb_slave_txfifo: directed and randomized checks of wb_slave_txfifo against a queue model.
module tb_wb_slave_txfifo;
  localparam int         D    = 8;
  localparam int         AW   = 1;
  localparam logic [7:0] BASE = 8'h40;
`ifdef WB_SLAVE_TXFIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 1'b0, rst, cyc, stb, we, tx_ready;
  logic [7:0] adr, dat_i, dat_o, tx_data, rd;
  logic ack, err, tx_valid, irq;
  int n_cmp = 0, n_fail = 0;
  logic [7:0] q[$];
  logic m_ovf, m_en;
  logic [3:0] m_thr;

  wb_slave_txfifo #(.FIFO_DEPTH(D), .ACK_WAIT(AW), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_irq();
    return m_en && q.size() <= int'(m_thr);
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] off);
    case (off)
      2'd0: return q.size() != 0 ? q[0] : 8'h00;
      2'd1: return {4'h0, m_irq(), m_ovf, q.size() == D, q.size() == 0};
      2'd2: return 8'(q.size());
      default: return {m_en, 3'b000, m_thr};
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_en  = 1'b0;
    m_thr = 4'h0;
  endtask

  // One Wishbone transfer; popc raises tx_ready only for the commit cycle.
  task automatic wb_op(input bit w, input logic [7:0] a, input logic [7:0] d, input bit popc,
                       input string tag, output logic [7:0] r);
    bit hit, got, exp_err;
    int n;
    logic [7:0] exp_rd;
    hit    = a[7:2] == BASE[7:2];
    exp_rd = m_read(a[1:0]);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    got = 1'b0; n = 0; r = 8'h00;
    if (popc && AW == 0) tx_ready = 1'b1;
    while (!got && n < AW + 4) begin
      @(posedge clk); #1;
      n++;
      if (ack || err) begin
        got = 1'b1;
        r = dat_o;
      end else if (popc && n == AW) begin
        check({tag, "/head"}, tx_data, q[0]);
        tx_ready = 1'b1;
      end
    end
    tx_ready = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!hit) check({tag, "/noresp"}, {31'd0, got}, 32'd0);
    else begin
      if (popc && q.size() != 0) void'(q.pop_front());
      exp_err = 1'b0;
      if (w)
        case (a[1:0])
          2'd0: if (q.size() < D) q.push_back(d);
                else begin m_ovf = 1'b1; exp_err = ERR; end
          2'd1: if (d[2]) m_ovf = 1'b0;
          2'd2: exp_err = ERR;
          default: begin
            m_thr = d[3:0];
            m_en  = d[7];
            if (d[6]) q.delete();
          end
        endcase
      check({tag, "/latency"}, n, AW + 1);
      check({tag, "/ack"}, {31'd0, ack}, {31'd0, !exp_err});
      check({tag, "/err"}, {31'd0, err}, {31'd0, exp_err});
      if (!w) check({tag, "/rdata"}, r, exp_rd);
    end
    @(posedge clk); #1;
    check({tag, "/irq"}, {31'd0, irq}, {31'd0, m_irq()});
  endtask

  task automatic drain(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      tx_ready = 1'b1;
      check("drain/valid", {31'd0, tx_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) check("drain/data", tx_data, q[0]);
      @(posedge clk); #1;
      if (q.size() != 0) void'(q.pop_front());
    end
    tx_ready = 1'b0;
    @(posedge clk); #1;
    check("drain/irq", {31'd0, irq}, {31'd0, m_irq()});
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 8'h00; dat_i = 8'h00; tx_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst/ack", {31'd0, ack}, 32'd0);
    check("rst/err", {31'd0, err}, 32'd0);
    check("rst/irq", {31'd0, irq}, 32'd0);
    check("rst/tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst/dat_o", dat_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    wb_op(1'b1, BASE, 8'hA5, 1'b0, "wr_a5", rd);
    check("a5/tx_valid", {31'd0, tx_valid}, 32'd1);
    check("a5/tx_data", tx_data, 32'hA5);
    wb_op(1'b0, BASE + 8'd2, 8'h00, 1'b0, "level1", rd);
    check("a5/level", rd, 32'd1);
    wb_op(1'b0, BASE, 8'h00, 1'b0, "peek", rd);
    check("a5/peek", rd, 32'hA5);

    wb_op(1'b1, BASE + 8'd3, 8'h40, 1'b0, "flush0", rd);
    for (int i = 0; i < 9; i++) wb_op(1'b1, BASE, 8'(8'h10 + i), 1'b0, "fill", rd);
    wb_op(1'b0, BASE + 8'd1, 8'h00, 1'b0, "st_full", rd);
    check("ovf/status", rd, 32'h06);
    wb_op(1'b1, BASE + 8'd1, 8'h04, 1'b0, "st_clr", rd);
    wb_op(1'b0, BASE + 8'd1, 8'h00, 1'b0, "st_clred", rd);
    check("ovf/cleared", rd, 32'h02);

    wb_op(1'b1, BASE, 8'h99, 1'b1, "push_pop", rd);
    wb_op(1'b0, BASE + 8'd2, 8'h00, 1'b0, "pp_level", rd);
    check("pp/level", rd, 32'd8);
    wb_op(1'b0, BASE + 8'd1, 8'h00, 1'b0, "pp_status", rd);
    check("pp/status", rd, 32'h02);
    drain(9);

    for (int i = 0; i < 3; i++) wb_op(1'b1, BASE, 8'(8'h30 + i), 1'b0, "q3", rd);
    wb_op(1'b1, BASE + 8'd3, 8'h82, 1'b0, "ctrl82", rd);
    check("irq/low", {31'd0, irq}, 32'd0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    void'(q.pop_front());
    check("irq/lag", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq/rise", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 3; i++) wb_op(1'b1, BASE, 8'(8'h50 + i), 1'b0, "q5", rd);
    wb_op(1'b1, BASE + 8'd3, 8'h40, 1'b0, "flush5", rd);
    wb_op(1'b0, BASE + 8'd2, 8'h00, 1'b0, "fl_level", rd);
    check("flush/level", rd, 32'd0);
    check("flush/tx_valid", {31'd0, tx_valid}, 32'd0);

    wb_op(1'b1, BASE, 8'h11, 1'b0, "pre_abort", rd);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat_i = 8'h77;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check("abort/ack", {31'd0, ack || err}, 32'd0);
    @(posedge clk); #1;
    check("abort/ack2", {31'd0, ack || err}, 32'd0);
    wb_op(1'b0, BASE + 8'd2, 8'h00, 1'b0, "abort_level", rd);
    check("abort/level", rd, 32'd1);
    wb_op(1'b1, 8'h50, 8'h22, 1'b0, "miss_wr", rd);
    wb_op(1'b0, 8'h53, 8'h00, 1'b0, "miss_rd", rd);

    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; dat_i = 8'h66;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("midrst/ack", {31'd0, ack}, 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("midrst/ack2", {31'd0, ack}, 32'd0);
    check("midrst/tx_valid", {31'd0, tx_valid}, 32'd0);
    wb_op(1'b0, BASE + 8'd2, 8'h00, 1'b0, "midrst_level", rd);

    for (int i = 0; i < 120; i++) begin
      int k;
      logic [7:0] a;
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 15) == 0 ? 8'h50 : BASE;
      case (k)
        0, 1, 2, 3: wb_op(1'b1, a, 8'($urandom), 1'b0, "rnd_wdata", rd);
        4: wb_op(1'b0, a, 8'h00, 1'b0, "rnd_rdata", rd);
        5: wb_op(1'b0, a + 8'd1, 8'h00, 1'b0, "rnd_status", rd);
        6: wb_op(1'($urandom), a + 8'd2, 8'($urandom), 1'b0, "rnd_level", rd);
        7: wb_op(1'b1, a + 8'd3, {1'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), 4'($urandom)},
                 1'b0, "rnd_ctrl", rd);
        8: wb_op(1'b1, a + 8'd1, 8'($urandom), 1'b0, "rnd_stclr", rd);
        default: drain($urandom_range(1, 4));
      endcase
    end
    wb_op(1'b0, BASE + 8'd3, 8'h00, 1'b0, "end_ctrl", rd);
    drain(D + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_slave_txfifo.md
WB_SLAVE_TXFIFO -- requirements
Module: wb_slave_txfifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, egress FIFO depth in bytes (power of two, 2..128).
REQ-002 SHALL have parameter ACK_WAIT, default 1, wait states inserted before the response (0..7).
REQ-003 SHALL have parameter BASE_ADDR, default 8'h40, 4-byte register window base (bits [1:0] ignored).
REQ-004 SHALL have wb_clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have wb_rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have wb_cyc_i, wb_stb_i and wb_we_i, input, 1 each, Wishbone classic cycle, strobe and write-enable.
REQ-007 SHALL have wb_adr_i, input, 8, byte address; wb_dat_i, input, 8, write data.
REQ-008 SHALL have wb_dat_o, output, 8, read data, valid only while wb_ack_o is high.
REQ-009 SHALL have wb_ack_o and wb_err_o, output, 1 each, single-cycle termination.
REQ-010 SHALL have tx_valid, output, 1; tx_data, output, 8; and tx_ready, input, 1; egress stream of FIFO head.
REQ-011 SHALL have irq, output, 1, level interrupt.

Function
REQ-012 SHALL respond only when wb_adr_i[7:2] == BASE_ADDR[7:2], and SHALL drive no ack or err for other addresses.
REQ-013 SHALL implement register 0x0 DATA: a write pushes wb_dat_i; a read returns the FIFO head without popping (0x00 when empty).
REQ-014 SHALL implement register 0x1 STATUS (R): [0] empty, [1] full, [2] overflow (sticky), [3] irq, [7:4] 0; writing 1 to bit 2 clears overflow.
REQ-015 SHALL implement register 0x2 LEVEL (R): byte count 0..FIFO_DEPTH; writes ignored.
REQ-016 SHALL implement register 0x3 CTRL (RW): [3:0] threshold, [6] flush (self-clearing, reads 0), [7] irq_en, [5:4] read 0.
REQ-017 SHALL use FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-018 IDLE: on wb_cyc_i & wb_stb_i & address match, SHALL latch address, data and we, then go to WAIT, or to RESP directly when ACK_WAIT = 0.
REQ-019 WAIT: SHALL count ACK_WAIT cycles then go to RESP; if wb_cyc_i falls, SHALL return to IDLE with no side effect.
REQ-020 RESP: SHALL assert wb_ack_o (or wb_err_o) for exactly one cycle, commit the write or pop-free read in that cycle, and return to IDLE.
REQ-021 Latency from the accepted strobe edge to ack SHALL be ACK_WAIT+1 cycles; minimum spacing between transfers is ACK_WAIT+2 cycles.
REQ-022 tx_valid SHALL equal !empty and tx_data SHALL equal the head, combinationally; a pop SHALL occur on tx_valid & tx_ready.
REQ-023 A simultaneous push and pop SHALL leave LEVEL unchanged, including when full; the pop frees the slot and the push is accepted.
REQ-024 A push when full without a concurrent pop SHALL drop the data and set overflow.
REQ-025 A flush SHALL empty the FIFO in the commit cycle and take priority over a concurrent pop or push.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH, and LEVEL SHALL be $clog2(FIFO_DEPTH)+1 bits, zero-extended to 8 bits.
REQ-027 irq SHALL equal irq_en & (LEVEL <= threshold), registered with one cycle of latency.

Reset
REQ-028 On wb_rst_i, the FSM SHALL go to IDLE; FIFO empty; overflow 0; CTRL 0x00; wb_ack_o, wb_err_o, irq, tx_valid and wb_dat_o SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer with no ack and no commit; the FIFO contents SHALL be discarded.

Configuration
REQ-030 With WB_SLAVE_TXFIFO_ERR_EN defined: a DATA write while full with no concurrent pop SHALL terminate with wb_err_o instead of wb_ack_o (data dropped, overflow still set), and a write to LEVEL SHALL terminate with wb_err_o.
REQ-031 Without WB_SLAVE_TXFIFO_ERR_EN: wb_err_o SHALL be tied to 0 and every matched access SHALL terminate with wb_ack_o.

Verification
REQ-032 Reset, ACK_WAIT=1: write 0xA5 to 0x40 with tx_ready=0 -> ack 2 cycles after strobe; tx_valid=1, tx_data=0xA5, LEVEL reads 1.
REQ-033 Push 9 bytes into FIFO_DEPTH=8 with tx_ready=0 -> STATUS=0x06 (full, overflow); 9th byte lost; write 0x04 to STATUS -> overflow cleared.
REQ-034 FIFO full, tx_ready=1 in the same cycle as a DATA write commit -> LEVEL stays 8; no overflow; byte order preserved.
REQ-035 CTRL=0x82, LEVEL 3 drained to 2 -> irq rises one cycle later; write CTRL=0x40 with 5 bytes queued -> LEVEL=0, tx_valid=0.
REQ-036 Drop wb_cyc_i during WAIT (ACK_WAIT=3) -> no ack and no push; access to 0x50 -> no ack/err; with ERR_EN, full write -> wb_err_o pulse.
